// File: rtl/interleaved_bank_bram_pkg.sv
// Shared sizing for the interleaved banked memory: default geometry and the LOG2 helper macro.
// Address split: the low BB bits select the bank and the remaining bits select the row.
`define LOG2(x) ($clog2(x))

package interleaved_bank_bram_pkg;
  localparam int P_BANKS  = 4;
  localparam int P_LANES  = 4;
  localparam int P_WIDTH  = 16;
  localparam int P_DEPTH  = 256;
  localparam int P_RD_LAT = 2;
  localparam int P_BB     = `LOG2(P_BANKS);
  localparam int P_ROW_W  = `LOG2(P_DEPTH);
  localparam int P_ADDR   = P_BB + P_ROW_W;
endpackage

// File: rtl/interleaved_bank_bram_if.sv
// Write port plus per-lane read request/return bundle for the banked memory.
// Read grants are combinational (rd_ready); return data has no backpressure.
interface interleaved_bank_bram_if #(
  parameter int LANES = interleaved_bank_bram_pkg::P_LANES,
  parameter int WIDTH = interleaved_bank_bram_pkg::P_WIDTH,
  parameter int ADDR  = interleaved_bank_bram_pkg::P_ADDR
);
  localparam int WE = WIDTH / 8;

  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR-1:0]        wr_addr;
  logic [WE-1:0]          wr_be;
  logic [WIDTH-1:0]       wr_data;
  logic [LANES-1:0]       rd_valid;
  logic [LANES-1:0]       rd_ready;
  logic [LANES*ADDR-1:0]  rd_addr;
  logic [LANES*WIDTH-1:0] rd_data;
  logic [LANES-1:0]       rd_dvalid;

  modport master (
    output wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rd_data, rd_dvalid
  );

  modport slave (
    input  wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rd_data, rd_dvalid
  );
endinterface

// File: rtl/interleaved_bank_bram_rr_arbiter.sv
// Round-robin arbiter, zero-latency one-hot grant; the pointer advances past each winner.
// No backpressure: a request is either granted this cycle or must be held by the requester.
module rr_arbiter
  import interleaved_bank_bram_pkg::*;
#(
  parameter int N = P_LANES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_found;
  int            w_idx;

  // First requester at or after the pointer, scanning upward modulo N.
  always_comb begin
    o_gnt     = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(r_ptr) + k) % N;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
        w_ptr_nxt    = PW'((w_idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else        r_ptr <= w_ptr_nxt;
  end
endmodule

// File: rtl/interleaved_bank_bram.sv
// Address-interleaved multi-lane BRAM: per-bank round-robin with same-address coalescing, RD_LAT-cycle reads.
// Grants are combinational and stalled lanes hold their request; writes are always accepted out of reset.
module interleaved_bank_bram
  import interleaved_bank_bram_pkg::*;
#(
  parameter int BANKS  = P_BANKS,
  parameter int LANES  = P_LANES,
  parameter int WIDTH  = P_WIDTH,
  parameter int DEPTH  = P_DEPTH,
  parameter int RD_LAT = P_RD_LAT,
  parameter int ADDR   = `LOG2(BANKS*DEPTH)
) (
  input logic                    clk,
  input logic                    rstn,
  interleaved_bank_bram_if.slave bus
);
  localparam int BB = `LOG2(BANKS);
  localparam int WE = WIDTH / 8;

  logic [ADDR-1:0]        w_addr      [LANES];
  logic [BB-1:0]          w_lane_bank [LANES];
  logic [LANES-1:0]       w_req       [BANKS];
  logic [LANES-1:0]       w_gnt       [BANKS];
  logic [ADDR-1:0]        w_win_addr  [BANKS];
  logic [BANKS-1:0]       w_bank_en;
  logic [WIDTH-1:0]       w_bank_q    [BANKS];
  logic [LANES-1:0]       w_rd_ready;
  logic                   w_wr_fire;
  logic                   r_wr_ready;
  logic [LANES-1:0]       r_v0;
  logic [BB-1:0]          r_sel       [LANES];
  logic [LANES-1:0]       w_sv        [RD_LAT];
  logic [LANES*WIDTH-1:0] w_sd        [RD_LAT];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_addr[i]      = bus.rd_addr[i*ADDR +: ADDR];
      w_lane_bank[i] = w_addr[i][BB-1:0];
    end
  end

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      w_req[b] = '0;
      for (int i = 0; i < LANES; i++)
        w_req[b][i] = bus.rd_valid[i] && (w_lane_bank[i] == BB'(b));
    end
  end

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      w_win_addr[b] = '0;
      w_bank_en[b]  = |w_gnt[b];
      for (int i = 0; i < LANES; i++)
        if (w_gnt[b][i]) w_win_addr[b] = w_addr[i];
    end
  end

  // Coalescing: any requester of the bank sharing the winner's address rides along.
  always_comb begin
    w_rd_ready = '0;
    for (int i = 0; i < LANES; i++)
      w_rd_ready[i] = bus.rd_valid[i] && w_bank_en[w_lane_bank[i]]
                      && (w_addr[i] == w_win_addr[w_lane_bank[i]]);
  end

  assign w_wr_fire    = bus.wr_valid && r_wr_ready;
  assign bus.wr_ready = r_wr_ready;
  assign bus.rd_ready = w_rd_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_wr_ready <= 1'b0;
    else       r_wr_ready <= 1'b1;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;
    logic             w_wr_sel;

    assign w_wr_sel = w_wr_fire && (bus.wr_addr[BB-1:0] == BB'(b));

    rr_arbiter #(.N(LANES)) u_arb (
      .clk   (clk),
      .rst_n (rstn),
      .i_req (w_req[b]),
      .o_gnt (w_gnt[b])
    );

    // Read and write in one block: a same-cycle read sees the pre-write word.
    always_ff @(posedge clk) begin
      if (w_wr_sel)
        for (int k = 0; k < WE; k++)
          if (bus.wr_be[k])
            r_mem[bus.wr_addr[ADDR-1:BB]][k*8 +: 8] <= bus.wr_data[k*8 +: 8];
      if (w_bank_en[b])
        r_q <= r_mem[w_win_addr[b][ADDR-1:BB]];
    end

    assign w_bank_q[b] = r_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v0 <= '0;
      for (int i = 0; i < LANES; i++) r_sel[i] <= '0;
    end else begin
      r_v0 <= w_rd_ready;
      for (int i = 0; i < LANES; i++) r_sel[i] <= w_lane_bank[i];
    end
  end

  // Data is zeroed whenever its valid is low, so a reset clears the output at once.
  always_comb begin
    w_sv[0] = r_v0;
    w_sd[0] = '0;
    for (int i = 0; i < LANES; i++)
      w_sd[0][i*WIDTH +: WIDTH] = r_v0[i] ? w_bank_q[r_sel[i]] : '0;
  end

  for (genvar k = 1; k < RD_LAT; k++) begin : g_stage
    logic [LANES-1:0]       r_v;
    logic [LANES*WIDTH-1:0] r_d;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_v <= '0;
        r_d <= '0;
      end else begin
        r_v <= w_sv[k-1];
        r_d <= w_sd[k-1];
      end
    end

    assign w_sv[k] = r_v;
    assign w_sd[k] = r_d;
  end

  assign bus.rd_dvalid = w_sv[RD_LAT-1];
  assign bus.rd_data   = w_sd[RD_LAT-1];
endmodule

// File: tb/tb_interleaved_bank_bram.sv
// Bench: four DUTs (RD_LAT 1..4) on shared stimulus, checked against a word-addressed memory model.
module tb_interleaved_bank_bram;
  localparam int LANES = 4;
  localparam int BANKS = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int ADDR  = `LOG2(BANKS*DEPTH);
  localparam int NDUT  = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_valid = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [1:0]  wr_be = '0;
  logic [15:0] wr_data = '0;
  logic [3:0]  rd_valid = '0;
  logic [39:0] rd_addr = '0;

  logic [3:0]  o_ready [NDUT];
  logic [3:0]  o_dv    [NDUT];
  logic [63:0] o_data  [NDUT];
  logic        o_wrr   [NDUT];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    interleaved_bank_bram_if #(.LANES(LANES), .WIDTH(WIDTH), .ADDR(ADDR)) u_if ();
    assign u_if.wr_valid = wr_valid;
    assign u_if.wr_addr  = wr_addr;
    assign u_if.wr_be    = wr_be;
    assign u_if.wr_data  = wr_data;
    assign u_if.rd_valid = rd_valid;
    assign u_if.rd_addr  = rd_addr;
    assign o_ready[g] = u_if.rd_ready;
    assign o_dv[g]    = u_if.rd_dvalid;
    assign o_data[g]  = u_if.rd_data;
    assign o_wrr[g]   = u_if.wr_ready;

    interleaved_bank_bram #(
      .BANKS(BANKS), .LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(g + 1), .ADDR(ADDR)
    ) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (u_if.slave)
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 291) ^ 16'hC35A;
  endfunction

  function automatic logic [9:0] lane_addr(input int i);
    return rd_addr[i*10 +: 10];
  endfunction

  // Reference model: flat memory indexed by global address, one pointer per bank.
  logic [15:0] mem [1024];
  int          mptr [BANKS];
  logic [3:0]  pend_v [NDUT][8];
  logic [63:0] pend_d [NDUT][8];
  bit          mdl_wrrdy = 1'b0;
  int          cyc = 0;

  always @(negedge clk) begin
    int         s;
    int         win;
    int         idx;
    logic [3:0] er;
    if (!rstn) begin
      for (int d = 0; d < NDUT; d++) begin
        for (int k = 0; k < 8; k++) begin
          pend_v[d][k] = '0;
          pend_d[d][k] = '0;
        end
        chk("reset_dvalid", 64'(o_dv[d]), 64'd0);
        chk("reset_data", o_data[d], 64'd0);
        chk("reset_wr_ready", 64'(o_wrr[d]), 64'd0);
      end
      for (int b = 0; b < BANKS; b++) mptr[b] = 0;
      mdl_wrrdy = 1'b0;
    end else begin
      s = cyc % 8;
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("rd_dvalid_lat%0d", d + 1), 64'(o_dv[d]), 64'(pend_v[d][s]));
        chk($sformatf("rd_data_lat%0d", d + 1), o_data[d], pend_d[d][s]);
        chk($sformatf("wr_ready_lat%0d", d + 1), 64'(o_wrr[d]), 64'(mdl_wrrdy));
        pend_v[d][s] = '0;
        pend_d[d][s] = '0;
      end
      er = '0;
      for (int b = 0; b < BANKS; b++) begin
        win = -1;
        for (int k = 0; k < LANES; k++) begin
          idx = (mptr[b] + k) % LANES;
          if (win < 0 && rd_valid[idx] && (int'(lane_addr(idx)) % BANKS) == b) win = idx;
        end
        if (win >= 0) begin
          for (int i = 0; i < LANES; i++)
            if (rd_valid[i] && lane_addr(i) == lane_addr(win)) er[i] = 1'b1;
          mptr[b] = (win + 1) % LANES;
        end
      end
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("rd_ready_lat%0d", d + 1), 64'(o_ready[d]), 64'(er));
        for (int i = 0; i < LANES; i++)
          if (er[i]) begin
            pend_v[d][(cyc + d + 1) % 8][i] = 1'b1;
            pend_d[d][(cyc + d + 1) % 8][i*16 +: 16] = mem[lane_addr(i)];
          end
      end
      if (wr_valid && mdl_wrrdy)
        for (int k = 0; k < 2; k++)
          if (wr_be[k]) mem[wr_addr][k*8 +: 8] = wr_data[k*8 +: 8];
      mdl_wrrdy = 1'b1;
    end
    cyc++;
  end

  typedef struct {
    logic [3:0]  valid;
    logic [39:0] addrs;
    logic [3:0]  ready;
  } vec_t;

  vec_t        tbl [8];
  logic [63:0] exp_d;
  logic [15:0] oldw;
  logic [15:0] neww;
  logic [3:0]  exp_r;
  logic [3:0]  last_rdy;
  int          stall [LANES];
  bit          dv_seen;

  initial begin
    // Expectations depend on pointer history from reset, so the order matters.
    tbl[0] = '{4'b1111, {10'd3,  10'd2,  10'd1,  10'd0},  4'b1111};
    tbl[1] = '{4'b1111, {10'd20, 10'd20, 10'd20, 10'd20}, 4'b1111};
    tbl[2] = '{4'b0101, {10'd0,  10'd11, 10'd0,  10'd7},  4'b0001};
    tbl[3] = '{4'b0101, {10'd0,  10'd11, 10'd0,  10'd7},  4'b0100};
    tbl[4] = '{4'b1011, {10'd13, 10'd0,  10'd9,  10'd9},  4'b1000};
    tbl[5] = '{4'b1011, {10'd13, 10'd0,  10'd9,  10'd9},  4'b0011};
    tbl[6] = '{4'b0000, {10'd5,  10'd6,  10'd7,  10'd8},  4'b0000};
    tbl[7] = '{4'b1111, {10'd19, 10'd14, 10'd9,  10'd4},  4'b1111};

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 1024; a++) begin
      wr_valid = 1'b1; wr_addr = 10'(a); wr_be = 2'b11; wr_data = pat(a);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;

    for (int v = 0; v < 8; v++) begin
      rd_valid = tbl[v].valid;
      rd_addr  = tbl[v].addrs;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", v), 64'(o_ready[1]), 64'(tbl[v].ready));
      exp_d = '0;
      for (int i = 0; i < LANES; i++)
        if (tbl[v].ready[i]) exp_d[i*16 +: 16] = pat(int'(tbl[v].addrs[i*10 +: 10]));
      @(posedge clk); #1;
      rd_valid = '0;
      repeat (2) @(negedge clk);
      chk($sformatf("tbl%0d_dvalid", v), 64'(o_dv[1]), 64'(tbl[v].ready));
      chk($sformatf("tbl%0d_data", v), o_data[1], exp_d);
      @(posedge clk); #1;
    end

    rd_valid = 4'b0100;
    rd_addr  = {10'd0, 10'd6, 10'd0, 10'd0};
    @(negedge clk);
    chk("rst_flight_grant", 64'(o_ready[1]), 64'(4'b0100));
    @(posedge clk); #1;
    rstn = 1'b0;
    rd_valid = '0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_dvalid_immediate", 64'(o_dv[d]), 64'd0);
      chk("rst_data_immediate", o_data[d], 64'd0);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    dv_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) if (o_dv[d] != 4'b0000) dv_seen = 1'b1;
    end
    chk("no_dvalid_after_release", 64'(dv_seen), 64'd0);

    @(posedge clk); #1;
    rd_valid = 4'b1111;
    rd_addr  = {10'd16, 10'd12, 10'd8, 10'd4};
    for (int k = 0; k < 5; k++) begin
      exp_r = 4'b0001;
      exp_r = exp_r << (k % 4);
      @(negedge clk);
      chk($sformatf("conflict_cycle%0d", k), 64'(o_ready[1]), 64'(exp_r));
      @(posedge clk); #1;
    end
    rd_valid = '0;
    repeat (3) @(posedge clk);
    #1;

    oldw = pat(5);
    neww = {oldw[15:8], 8'hEF};
    wr_valid = 1'b1; wr_addr = 10'd5; wr_be = 2'b01; wr_data = 16'hBEEF;
    rd_valid = 4'b0001; rd_addr = {10'd0, 10'd0, 10'd0, 10'd5};
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(posedge clk); #1;
    rd_valid = '0;
    @(negedge clk);
    chk("collision_old_word", 64'(o_data[1][15:0]), 64'(oldw));
    @(negedge clk);
    chk("collision_next_read", 64'(o_data[1][15:0]), 64'(neww));

    last_rdy = '0;
    for (int i = 0; i < LANES; i++) stall[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < LANES; i++)
        if (!(rd_valid[i] && !last_rdy[i])) begin
          rd_valid[i] = ($urandom_range(0, 3) != 0);
          rd_addr[i*10 +: 10] = 10'($urandom_range(0, 31));
        end
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 10'($urandom_range(0, 31));
      wr_be    = 2'($urandom_range(0, 3));
      wr_data  = 16'($urandom);
      @(negedge clk);
      last_rdy = o_ready[1];
      for (int i = 0; i < LANES; i++) begin
        if (rd_valid[i] && !last_rdy[i]) stall[i]++;
        else stall[i] = 0;
        if (rd_valid[i]) chk("starvation_bound", 64'(stall[i] < LANES), 64'd1);
      end
    end
    @(posedge clk); #1;
    rd_valid = '0;
    wr_valid = 1'b0;
    repeat (6) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
